// File: rtl/hicore_icb_arbt.sv
// hicore_icb_arbt: N-to-1 ICB arbiter; an outstanding-source FIFO routes responses back in order.
// Define HICORE_ARBT_ROUND_ROBIN_EN for round-robin grant, else fixed priority (lowest index wins).
`ifndef HiCore_ADDR_SIZE
`define HiCore_ADDR_SIZE 32
`endif
`ifndef HiCore_REG_SIZE
`define HiCore_REG_SIZE 32
`endif

module hicore_icb_arbt #(
  parameter int AW         = `HiCore_ADDR_SIZE,
  parameter int DW         = `HiCore_REG_SIZE,
  parameter int ARBT_NUM   = 2,
  parameter int ARBT_PTR_W = 1,
  parameter int OUTS_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ARBT_NUM-1:0]      i_bus_icb_cmd_valid,
  output logic [ARBT_NUM-1:0]      i_bus_icb_cmd_ready,
  input  logic [ARBT_NUM-1:0]      i_bus_icb_cmd_read,
  input  logic [ARBT_NUM*AW-1:0]   i_bus_icb_cmd_addr,
  input  logic [ARBT_NUM*DW-1:0]   i_bus_icb_cmd_wdata,
  input  logic [ARBT_NUM*DW/8-1:0] i_bus_icb_cmd_wmask,
  output logic [ARBT_NUM-1:0]      i_bus_icb_rsp_valid,
  input  logic [ARBT_NUM-1:0]      i_bus_icb_rsp_ready,
  output logic [ARBT_NUM-1:0]      i_bus_icb_rsp_err,
  output logic [ARBT_NUM*DW-1:0]   i_bus_icb_rsp_rdata,
  output logic                     o_icb_cmd_valid,
  input  logic                     o_icb_cmd_ready,
  output logic                     o_icb_cmd_read,
  output logic [AW-1:0]            o_icb_cmd_addr,
  output logic [DW-1:0]            o_icb_cmd_wdata,
  output logic [DW/8-1:0]          o_icb_cmd_wmask,
  input  logic                     o_icb_rsp_valid,
  output logic                     o_icb_rsp_ready,
  input  logic                     o_icb_rsp_err,
  input  logic [DW-1:0]            o_icb_rsp_rdata
);

  localparam int MW    = DW / 8;
  localparam int FP_W  = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUTS_DEPTH + 1);

  logic [ARBT_PTR_W-1:0] r_fifo [OUTS_DEPTH];
  logic [FP_W-1:0]       r_wptr, r_rptr;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_lock;
  logic [ARBT_PTR_W-1:0] r_lock_idx;

  logic [ARBT_PTR_W-1:0] w_arb_grant, w_grant, w_head;
  logic                  w_full, w_empty, w_cmd_fire, w_rsp_fire;

  assign w_full  = (r_cnt == CNT_W'(OUTS_DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_head  = r_fifo[r_rptr];

`ifdef HICORE_ARBT_ROUND_ROBIN_EN
  logic [ARBT_PTR_W-1:0] r_rr_ptr;

  // Scan downward so the last hit is the first valid port at or after r_rr_ptr.
  always_comb begin
    w_arb_grant = '0;
    for (int i = ARBT_NUM - 1; i >= 0; i--) begin
      if (i_bus_icb_cmd_valid[(int'(r_rr_ptr) + i) % ARBT_NUM])
        w_arb_grant = ARBT_PTR_W'((int'(r_rr_ptr) + i) % ARBT_NUM);
    end
  end
`else
  always_comb begin
    w_arb_grant = '0;
    for (int i = ARBT_NUM - 1; i >= 0; i--) begin
      if (i_bus_icb_cmd_valid[i]) w_arb_grant = ARBT_PTR_W'(i);
    end
  end
`endif

  assign w_grant         = r_lock ? r_lock_idx : w_arb_grant;
  assign o_icb_cmd_valid = i_bus_icb_cmd_valid[w_grant] & ~w_full;
  assign o_icb_cmd_read  = i_bus_icb_cmd_read[w_grant];
  assign o_icb_cmd_addr  = i_bus_icb_cmd_addr[w_grant*AW +: AW];
  assign o_icb_cmd_wdata = i_bus_icb_cmd_wdata[w_grant*DW +: DW];
  assign o_icb_cmd_wmask = i_bus_icb_cmd_wmask[w_grant*MW +: MW];
  assign w_cmd_fire      = o_icb_cmd_valid & o_icb_cmd_ready;

  assign o_icb_rsp_ready = ~w_empty & i_bus_icb_rsp_ready[w_head];
  assign w_rsp_fire      = o_icb_rsp_valid & o_icb_rsp_ready;

  genvar gi;
  generate
    for (gi = 0; gi < ARBT_NUM; gi++) begin : g_port
      assign i_bus_icb_cmd_ready[gi] = (w_grant == ARBT_PTR_W'(gi)) & o_icb_cmd_valid & o_icb_cmd_ready;
      assign i_bus_icb_rsp_valid[gi] = (w_head == ARBT_PTR_W'(gi)) & o_icb_rsp_valid & ~w_empty;
      assign i_bus_icb_rsp_err[gi]   = o_icb_rsp_err;
      assign i_bus_icb_rsp_rdata[gi*DW +: DW] = o_icb_rsp_rdata;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_cmd_fire) r_fifo[r_wptr] <= w_grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else begin
      if (w_cmd_fire)
        r_wptr <= (r_wptr == FP_W'(OUTS_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      if (w_rsp_fire)
        r_rptr <= (r_rptr == FP_W'(OUTS_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
      if (w_cmd_fire & ~w_rsp_fire)
        r_cnt <= r_cnt + 1'b1;
      else if (~w_cmd_fire & w_rsp_fire)
        r_cnt <= r_cnt - 1'b1;
      // A presented-but-stalled command pins the grant until it is accepted.
      if (w_cmd_fire) begin
        r_lock <= 1'b0;
      end else if (o_icb_cmd_valid) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_grant;
      end
    end
  end

`ifdef HICORE_ARBT_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_rr_ptr <= '0;
    else if (w_cmd_fire)
      r_rr_ptr <= (w_grant == ARBT_PTR_W'(ARBT_NUM - 1)) ? '0 : w_grant + 1'b1;
  end
`endif

endmodule

// File: tb/tb_hicore_icb_arbt.sv
// Directed self-checking bench for hicore_icb_arbt (2 ports, depth 4); expectations follow
// HICORE_ARBT_ROUND_ROBIN_EN when defined, fixed priority otherwise.
module tb_hicore_icb_arbt;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int N  = 2;
  localparam int MW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  cv, cr, crd, rv, rr, re;
  logic [N*AW-1:0] ca;
  logic [N*DW-1:0] cw, rd;
  logic [N*MW-1:0] cm;
  logic          ocv, ocr, ocrd, orv, orr, ore;
  logic [AW-1:0] oca;
  logic [DW-1:0] ocw, ordata;
  logic [MW-1:0] ocm;
  logic [1:0]    exp_g;

  int n_cmp = 0;
  int n_bad = 0;

  hicore_icb_arbt #(.AW(AW), .DW(DW), .ARBT_NUM(N), .ARBT_PTR_W(1), .OUTS_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_bus_icb_cmd_valid(cv), .i_bus_icb_cmd_ready(cr), .i_bus_icb_cmd_read(crd),
    .i_bus_icb_cmd_addr(ca), .i_bus_icb_cmd_wdata(cw), .i_bus_icb_cmd_wmask(cm),
    .i_bus_icb_rsp_valid(rv), .i_bus_icb_rsp_ready(rr), .i_bus_icb_rsp_err(re),
    .i_bus_icb_rsp_rdata(rd),
    .o_icb_cmd_valid(ocv), .o_icb_cmd_ready(ocr), .o_icb_cmd_read(ocrd),
    .o_icb_cmd_addr(oca), .o_icb_cmd_wdata(ocw), .o_icb_cmd_wmask(ocm),
    .o_icb_rsp_valid(orv), .o_icb_rsp_ready(orr), .o_icb_rsp_err(ore),
    .o_icb_rsp_rdata(ordata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    cv = '0; ocr = 1'b0; orv = 1'b0; ore = 1'b0; ordata = '0; rr = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    idle();
    crd = 2'b11;
    ca  = {32'hA000_0001, 32'h8000_0000};
    cw  = {32'h0000_BBBB, 32'h0000_AAAA};
    cm  = {4'h3, 4'hF};

    // Reset state
    rst_n = 1'b0;
    tick();
    chk("rst_cmd_ready", 64'(cr), 64'(0));
    chk("rst_cmd_valid", 64'(ocv), 64'(0));
    chk("rst_rsp_ready", 64'(orr), 64'(0));
    chk("rst_rsp_valid", 64'(rv), 64'(0));
    rst_n = 1'b1;
    tick();

    // Single read from port 0, response next cycle
    cv = 2'b01; ocr = 1'b1; rr = 2'b11;
    settle();
    chk("t2_cmd_valid", 64'(ocv), 64'(1));
    chk("t2_cmd_addr", 64'(oca), 64'(32'h8000_0000));
    chk("t2_cmd_wmask", 64'(ocm), 64'(4'hF));
    chk("t2_cmd_ready", 64'(cr), 64'(2'b01));
    tick();
    cv = 2'b00; orv = 1'b1; ordata = 32'h1234_5678;
    settle();
    chk("t2_rsp_valid", 64'(rv), 64'(2'b01));
    chk("t2_rsp_rdata0", 64'(rd[31:0]), 64'(32'h1234_5678));
    chk("t2_rsp_ready", 64'(orr), 64'(1));
    tick();
    orv = 1'b0;
    settle();
    chk("t2_empty_rsp_ready", 64'(orr), 64'(0));

    // Both ports valid continuously
    do_reset();
    cv = 2'b11; ocr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
`ifdef HICORE_ARBT_ROUND_ROBIN_EN
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      chk($sformatf("t3_grant%0d", k), 64'(cr), 64'(exp_g));
      chk($sformatf("t3_wdata%0d", k), 64'(ocw), (exp_g == 2'b01) ? 64'h0000_AAAA : 64'h0000_BBBB);
      tick();
    end
    settle();
    chk("t3_full_cmd_valid", 64'(ocv), 64'(0));
    chk("t3_full_cmd_ready", 64'(cr), 64'(0));

    // Lock: port 1 stalled 3 cycles while port 0 joins
    do_reset();
    cv = 2'b10; ocr = 1'b0;
    settle();
    chk("t4_c1_valid", 64'(ocv), 64'(1));
    chk("t4_c1_addr", 64'(oca), 64'(32'hA000_0001));
    chk("t4_c1_ready", 64'(cr), 64'(0));
    tick();
    cv = 2'b11;
    for (int k = 2; k <= 3; k++) begin
      settle();
      chk($sformatf("t4_c%0d_addr", k), 64'(oca), 64'(32'hA000_0001));
      chk($sformatf("t4_c%0d_ready", k), 64'(cr), 64'(0));
      tick();
    end
    ocr = 1'b1;
    settle();
    chk("t4_c4_ready", 64'(cr), 64'(2'b10));
    chk("t4_c4_read", 64'(ocrd), 64'(1));
    tick();
    cv = 2'b01;
    settle();
    chk("t4_after_ready", 64'(cr), 64'(2'b01));
    tick();

    // Fill FIFO with 0,1,1,0 then drain in order
    do_reset();
    ocr = 1'b1;
    begin
      logic [1:0] seq [4];
      seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b10; seq[3] = 2'b01;
      for (int k = 0; k < 4; k++) begin
        cv = seq[k];
        settle();
        chk($sformatf("t5_push%0d", k), 64'(cr), 64'(seq[k]));
        tick();
      end
    end
    cv = 2'b10;
    settle();
    chk("t5_stall_valid", 64'(ocv), 64'(0));
    chk("t5_stall_ready", 64'(cr), 64'(0));
    orv = 1'b1; ordata = 32'hCAFE_0001; rr = 2'b11;
    settle();
    chk("t5_rsp0_valid", 64'(rv), 64'(2'b01));
    chk("t5_pop_cycle_valid", 64'(ocv), 64'(0));
    tick();
    settle();
    chk("t5_release_valid", 64'(ocv), 64'(1));
    chk("t5_release_ready", 64'(cr), 64'(2'b10));
    chk("t5_rsp1_valid", 64'(rv), 64'(2'b10));
    tick();
    cv = 2'b00;
    settle();
    chk("t5_rsp2_valid", 64'(rv), 64'(2'b10));
    tick();

    // Head port (0) not ready for 2 cycles
    rr = 2'b10;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk($sformatf("t6_hold%0d_valid", k), 64'(rv), 64'(2'b01));
      chk($sformatf("t6_hold%0d_ready", k), 64'(orr), 64'(0));
      tick();
    end
    rr = 2'b11;
    settle();
    chk("t6_go_ready", 64'(orr), 64'(1));
    chk("t6_go_valid", 64'(rv), 64'(2'b01));
    chk("t6_go_rdata1", 64'(rd[63:32]), 64'(32'hCAFE_0001));
    tick();
    settle();
    chk("t6_last_valid", 64'(rv), 64'(2'b10));
    tick();
    settle();
    chk("t6_empty_valid", 64'(rv), 64'(0));
    chk("t6_empty_ready", 64'(orr), 64'(0));

    // Reset with an outstanding entry discards it
    do_reset();
    cv = 2'b01; ocr = 1'b1;
    tick();
    cv = 2'b00;
    rst_n = 1'b0;
    settle();
    rst_n = 1'b1;
    orv = 1'b1; rr = 2'b11;
    settle();
    chk("t7_late_rsp_valid", 64'(rv), 64'(0));
    chk("t7_late_rsp_ready", 64'(orr), 64'(0));
    tick();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
